// File: rtl/ysyx_24090003_sbus_mem.sv
// SimpleBus memory responder: word-addressed SRAM behind a one-outstanding
// request/response handshake with fixed or LFSR-jittered response latency.
module ysyx_24090003_sbus_mem #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned LATENCY     = 1,
    parameter bit          RAND_LAT    = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_we,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_wstrb,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;

    if (LATENCY > 15) begin : g_bad_latency
        $error("LATENCY must be in 0..15");
    end
    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("DEPTH_WORDS must be a power of two >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state, state_nx;
    logic [4:0]         cnt, cnt_nx;
    logic [4:0]         load;
    logic [7:0]         lfsr, lfsr_nx;
    logic [31:0]        rdata_q, rdata_nx;
    logic               err_q, err_nx;
    logic [31:0]        offs;
    logic               in_range;
    logic [IDX_W-1:0]   idx;
    logic               accept;

    logic [31:0] mem [DEPTH_WORDS];

    // Addresses below the base wrap to huge offsets and fall out of range.
    assign offs     = i_req_addr - ADDR_BASE;
    assign in_range = offs < SPAN;
    assign idx      = offs[IDX_W+1:2];

    assign o_req_ready  = (state == S_IDLE) && i_rst_n;
    assign accept       = i_req_valid && o_req_ready;
    assign o_resp_valid = (state == S_RESP);
    assign o_resp_rdata = rdata_q;
    assign o_resp_err   = err_q;

    assign load = 5'(LATENCY) + (RAND_LAT ? {3'b000, lfsr[1:0]} : 5'd0);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        lfsr_nx  = lfsr;
        rdata_nx = rdata_q;
        err_nx   = err_q;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    rdata_nx = (in_range && !i_req_we) ? mem[idx] : 32'h0;
                    err_nx   = !in_range;
                    cnt_nx   = load;
                    if (RAND_LAT) begin
                        lfsr_nx = {lfsr[6:0],
                                   lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                    end
                    state_nx = (load == 5'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt <= 5'd1) begin
                    cnt_nx   = 5'd0;
                    state_nx = S_RESP;
                end else begin
                    cnt_nx = cnt - 5'd1;
                end
            end
            S_RESP: begin
                if (i_resp_ready) begin
                    state_nx = S_IDLE;
                    rdata_nx = 32'h0;
                    err_nx   = 1'b0;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            cnt     <= 5'd0;
            lfsr    <= 8'hA5;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            lfsr    <= lfsr_nx;
            rdata_q <= rdata_nx;
            err_q   <= err_nx;
        end
    end

    // Array contents survive reset; writes land on the acceptance edge.
    always_ff @(posedge i_clk) begin
        if (accept && i_req_we && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (i_req_wstrb[b]) begin
                    mem[idx][8*b +: 8] <= i_req_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24090003_sbus_mem.sv
// Bench for ysyx_24090003_sbus_mem: four latency variants share one request
// bus and are checked against a word-array/LFSR reference model.
module tb_ysyx_24090003_sbus_mem;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int LAT [4] = '{1, 0, 4, 2};
    localparam logic [3:0] RND = 4'b1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_ready;
    logic [3:0]  rdy, vld, er;
    logic [31:0] rd [4];

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem_m [4096];
    logic [7:0]  lfsr_m;
    logic [31:0] pool [16];

    always #5 clk = ~clk;

    ysyx_24090003_sbus_mem #(.LATENCY(1), .RAND_LAT(1'b0)) u_l1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid),
        .o_req_ready(rdy[0]), .i_req_addr(req_addr), .i_req_we(req_we),
        .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
        .o_resp_valid(vld[0]), .i_resp_ready(resp_ready),
        .o_resp_rdata(rd[0]), .o_resp_err(er[0]));

    ysyx_24090003_sbus_mem #(.LATENCY(0), .RAND_LAT(1'b0)) u_l0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid),
        .o_req_ready(rdy[1]), .i_req_addr(req_addr), .i_req_we(req_we),
        .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
        .o_resp_valid(vld[1]), .i_resp_ready(resp_ready),
        .o_resp_rdata(rd[1]), .o_resp_err(er[1]));

    ysyx_24090003_sbus_mem #(.LATENCY(4), .RAND_LAT(1'b0)) u_l4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid),
        .o_req_ready(rdy[2]), .i_req_addr(req_addr), .i_req_we(req_we),
        .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
        .o_resp_valid(vld[2]), .i_resp_ready(resp_ready),
        .o_resp_rdata(rd[2]), .o_resp_err(er[2]));

    ysyx_24090003_sbus_mem #(.LATENCY(2), .RAND_LAT(1'b1)) u_rnd (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid),
        .o_req_ready(rdy[3]), .i_req_addr(req_addr), .i_req_we(req_we),
        .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
        .o_resp_valid(vld[3]), .i_resp_ready(resp_ready),
        .o_resp_rdata(rd[3]), .o_resp_err(er[3]));

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] wd,
                               input logic [3:0] ws);
        logic [31:0] off;
        off = addr - BASE;
        if (off < 32'h4000) begin
            for (int b = 0; b < 4; b++)
                if (ws[b]) mem_m[off[13:2]][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        @(negedge clk);
        while (rdy !== 4'hF && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (rdy !== 4'hF) chk("ready_timeout", {28'h0, rdy}, 32'hF);
    endtask

    task automatic accept(input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] ws);
        wait_ready();
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_wstrb = ws;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_we    = 1'($urandom);
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
    endtask

    task automatic xact(input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input int stall);
        logic [31:0] off, exp_rd;
        logic exp_err;
        int exp_lat [4];
        int seen_k [4];
        bit seen [4];
        bit fin [4];
        bit all_fin;
        off = addr - BASE;
        exp_err = !(off < 32'h4000);
        exp_rd = (!exp_err && !we) ? mem_m[off[13:2]] : 32'h0;
        for (int i = 0; i < 4; i++) begin
            exp_lat[i] = LAT[i] + (RND[i] ? int'(lfsr_m[1:0]) : 0);
            seen[i] = 1'b0;
            fin[i] = 1'b0;
            seen_k[i] = 0;
        end
        lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
        if (we) model_write(addr, wd, ws);
        resp_ready = (stall == 0);
        accept(we, addr, wd, ws);
        all_fin = 1'b0;
        for (int k = 0; k < 40 && !all_fin; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (seen[i] && !fin[i]) begin
                    chk($sformatf("drop_vld%0d", i), {31'h0, vld[i]}, 32'h0);
                    chk($sformatf("drop_rdy%0d", i), {31'h0, rdy[i]}, 32'h1);
                    fin[i] = 1'b1;
                end else if (!seen[i]) begin
                    if (vld[i]) begin
                        chk($sformatf("lat%0d", i), k, exp_lat[i]);
                        chk($sformatf("rdata%0d", i), rd[i], exp_rd);
                        chk($sformatf("err%0d", i), {31'h0, er[i]},
                            {31'h0, exp_err});
                        seen[i] = 1'b1;
                        seen_k[i] = k;
                        if (stall != 0) fin[i] = 1'b1;
                    end else begin
                        chk($sformatf("busy_rdy%0d", i), {31'h0, rdy[i]}, 32'h0);
                    end
                end
            end
            all_fin = fin[0] && fin[1] && fin[2] && fin[3];
        end
        if (!all_fin) chk("resp_timeout", 32'h0, 32'h1);
        if (stall != 0) begin
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("stall_vld%0d", i), {31'h0, vld[i]}, 32'h1);
                    chk($sformatf("stall_rdy%0d", i), {31'h0, rdy[i]}, 32'h0);
                    chk($sformatf("stall_rd%0d", i), rd[i], exp_rd);
                    chk($sformatf("stall_err%0d", i), {31'h0, er[i]},
                        {31'h0, exp_err});
                end
            end
            resp_ready = 1'b1;
            @(negedge clk);
            chk("release_vld", {28'h0, vld}, 32'h0);
            chk("release_rdy", {28'h0, rdy}, 32'hF);
        end
    endtask

    initial begin
        logic [31:0] a;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_addr = 32'h0;
        req_we = 1'b0;
        req_wdata = 32'h0;
        req_wstrb = 4'h0;
        resp_ready = 1'b0;
        lfsr_m = 8'hA5;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", {28'h0, rdy}, 32'h0);
        chk("rst_vld", {28'h0, vld}, 32'h0);
        chk("rst_err", {28'h0, er}, 32'h0);
        chk("rst_rdata", rd[0] | rd[1] | rd[2] | rd[3], 32'h0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_rdy", {28'h0, rdy}, 32'hF);
        chk("post_rst_vld", {28'h0, vld}, 32'h0);

        xact(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0);
        xact(1'b0, 32'h8000_0010, 32'h0, 4'h0, 0);

        xact(1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 0);
        xact(1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 0);
        xact(1'b0, 32'h8000_0020, 32'h0, 4'h0, 0);

        xact(1'b0, 32'h8000_0010, 32'h0, 4'h0, 5);

        xact(1'b0, 32'h8000_4000, 32'h0, 4'h0, 0);
        xact(1'b1, 32'h8000_0000, 32'h1234_5678, 4'hF, 0);
        xact(1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 0);
        xact(1'b0, 32'h8000_0000, 32'h0, 4'h0, 0);
        xact(1'b0, 32'h8000_3FFF, 32'h0, 4'h0, 0);

        xact(1'b1, 32'h8000_0010, 32'h0BAD_0BAD, 4'h0, 0);
        xact(1'b0, 32'h8000_0013, 32'h0, 4'h0, 0);

        // abort: write commits at acceptance, reset lands during the wait
        resp_ready = 1'b1;
        model_write(32'h8000_0104, 32'hCAFE_F00D, 4'hF);
        accept(1'b1, 32'h8000_0104, 32'hCAFE_F00D, 4'hF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_rdy", {28'h0, rdy}, 32'h0);
        @(negedge clk);
        chk("abort_vld", {28'h0, vld}, 32'h0);
        rst_n = 1'b1;
        lfsr_m = 8'hA5;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_no_resp", {28'h0, vld}, 32'h0);
            chk("abort_idle_rdy", {28'h0, rdy}, 32'hF);
        end
        xact(1'b0, 32'h8000_0104, 32'h0, 4'h0, 0);

        for (int p = 0; p < 16; p++) begin
            pool[p] = BASE + (32'($urandom_range(0, 4095)) << 2);
            xact(1'b1, pool[p], $urandom, 4'hF, 0);
        end
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 1)
                    a = 32'h8000_4000 + ($urandom & 32'h0FFF_FFFF);
                else
                    a = 32'h7000_0000 + ($urandom & 32'h0FFF_FFFF);
            end else begin
                a = pool[$urandom_range(0, 15)] | 32'($urandom_range(0, 3));
            end
            xact(1'($urandom), a, $urandom, 4'($urandom),
                 int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
